// File: rtl/ones_generator_pkg.sv
// rtl/ones_generator_pkg.sv - shared state encoding and count-width helper for ones_generator
package ones_generator_pkg;

    // FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width needed to hold 0..width inclusive
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/ones_generator.sv
// rtl/ones_generator.sv - bit-serial thermometer-code generator: count N in, word with N low ones out
//
// Ports:
//   clk         clock, all state updates on rising edge
//   resetn      asynchronous active-low reset
//   din_valid   count request valid
//   din_ready   block can accept a count (high only in IDLE)
//   din         requested number of ones, CW bits
//   dout_valid  generated word valid (held until dout_ready)
//   dout_ready  consumer accepts word
//   dout        generated word, DATA_WIDTH bits
//   dout_count  number of ones in dout (saturated count)
//   dout_sat    request exceeded DATA_WIDTH and was clamped
module ones_generator
    import ones_generator_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    localparam int CW         = count_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [CW-1:0]         din,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CW-1:0]         dout_count,
    output logic                  dout_sat
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(DATA_WIDTH);

    state_t        state;
    logic [CW-1:0] index;
    logic [CW-1:0] target;

    // Accept is decoded purely from state so it is high as soon as reset asserts
    assign din_ready  = (state == IDLE);
    assign dout_count = target;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sat   <= 1'b0;
            index      <= '0;
            target     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        if (din > MAX_COUNT) begin
                            target   <= MAX_COUNT;
                            dout_sat <= 1'b1;
                        end else begin
                            target   <= din;
                            dout_sat <= 1'b0;
                        end
                        dout  <= '0;
                        index <= '0;
                        state <= BUILD;
                    end
                end
                BUILD: begin
                    if (target == '0) begin
                        state      <= DONE;
                        dout_valid <= 1'b1;
                    end else begin
                        // The ones are contiguous from bit 0, so shifting a 1 in at the
                        // bottom sets exactly bit 'index' of the final word each cycle.
                        dout  <= {dout[DATA_WIDTH-2:0], 1'b1};
                        index <= index + CW'(1);
                        if (index + CW'(1) == target) begin
                            state      <= DONE;
                            dout_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (dout_ready) begin
                        state      <= IDLE;
                        dout_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ones_generator.sv
// tb/tb_ones_generator.sv - self-checking scoreboard bench for ones_generator
module tb_ones_generator;

    localparam int DW = 16;
    localparam int CW = 5;

    typedef struct packed {
        logic [DW-1:0] word;
        logic [CW-1:0] count;
        logic          sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          din_valid;
    logic          din_ready;
    logic [CW-1:0] din;
    logic          dout_valid;
    logic          dout_ready;
    logic [DW-1:0] dout;
    logic [CW-1:0] dout_count;
    logic          dout_sat;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_in     = 0;
    int   n_out    = 0;
    int   lat;

    ones_generator #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_count (dout_count),
        .dout_sat   (dout_sat)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int n);
        exp_t e;
        int   c;
        e.sat  = (n > DW);
        c      = e.sat ? DW : n;
        e.count = CW'(c);
        e.word = '0;
        for (int i = 0; i < c; i++) e.word[i] = 1'b1;
        return e;
    endfunction

    function automatic int popcount(input logic [DW-1:0] w);
        int c = 0;
        for (int i = 0; i < DW; i++) c += int'(w[i]);
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already set: records handshakes that the
    // next rising edge will complete, then advances to the following negedge.
    task automatic cycle();
        exp_t e;
        logic [DW-1:0] plus1;
        if (din_valid && din_ready) begin
            sb.push_back(model(int'(din)));
            n_in++;
        end
        if (dout_valid && dout_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                plus1 = dout + DW'(1);
                check("dout", 32'(dout), 32'(e.word));
                check("dout_count", 32'(dout_count), 32'(e.count));
                check("dout_sat", 32'(dout_sat), 32'(e.sat));
                check("popcount", 32'(popcount(dout)), 32'(e.count));
                check("contiguous", 32'(dout & plus1), 32'd0);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input int v);
        int k = 0;
        din_valid = 1'b1;
        din = CW'(v);
        while (!din_ready && k < 200) begin
            cycle();
            k++;
        end
        check("accept_timeout", 32'(din_ready), 32'd1);
        cycle();
        din_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!dout_valid && edges < 100) begin
            cycle();
            edges++;
        end
        check("valid_timeout", 32'(dout_valid), 32'd1);
    endtask

    initial begin
        int cyc;
        resetn     = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout_count", 32'(dout_count), 32'd0);
        check("rst_dout_sat", 32'(dout_sat), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        resetn = 1'b1;
        @(negedge clk);

        // Reset in the middle of BUILD discards the partial word
        accept(9);
        for (int i = 0; i < 4; i++) cycle();
        check("mid_build_ready", 32'(din_ready), 32'd0);
        resetn = 1'b0;
        #1;
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_valid", 32'(dout_valid), 32'd0);
        check("midrst_count", 32'(dout_count), 32'd0);
        check("midrst_sat", 32'(dout_sat), 32'd0);
        check("midrst_ready", 32'(din_ready), 32'd1);
        sb.delete();
        n_in = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        accept(3);
        wait_valid(lat);
        check("lat_3", 32'(lat), 32'd3);
        dout_ready = 1'b1;
        cycle();
        dout_ready = 1'b0;

        // din = 0
        dout_ready = 1'b1;
        accept(0);
        wait_valid(lat);
        check("lat_0", 32'(lat), 32'd1);
        cycle();
        check("ready_after_0", 32'(din_ready), 32'd1);
        check("valid_after_0", 32'(dout_valid), 32'd0);

        // din = 5
        accept(5);
        wait_valid(lat);
        check("lat_5", 32'(lat), 32'd5);
        cycle();

        // din = 16 and din = 31 (clamped)
        accept(16);
        wait_valid(lat);
        check("lat_16", 32'(lat), 32'd16);
        cycle();
        accept(31);
        wait_valid(lat);
        check("lat_31", 32'(lat), 32'd16);
        cycle();

        // Backpressure: word held, din pulses ignored
        dout_ready = 1'b0;
        accept(7);
        wait_valid(lat);
        check("lat_7", 32'(lat), 32'd7);
        for (int i = 0; i < 10; i++) begin
            din_valid = i[0];
            din = 5'd3;
            check("bp_valid", 32'(dout_valid), 32'd1);
            check("bp_dout", 32'(dout), 32'h007F);
            check("bp_ready", 32'(din_ready), 32'd0);
            cycle();
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        cycle();
        check("bp_released", 32'(dout_valid), 32'd0);
        check("bp_idle", 32'(din_ready), 32'd1);

        // Random back-to-back traffic
        check("pre_random_empty", 32'(sb.size()), 32'd0);
        n_in  = 0;
        n_out = 0;
        cyc   = 0;
        while ((n_in < 1000 || sb.size() != 0) && cyc < 60000) begin
            din_valid  = (n_in < 1000) && ($urandom_range(0, 7) != 0);
            din        = CW'($urandom_range(0, 31));
            dout_ready = ($urandom_range(0, 3) != 0);
            cycle();
            cyc++;
        end
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        check("random_timeout", 32'(cyc < 60000), 32'd1);
        check("random_in_count", 32'(n_in), 32'd1000);
        check("random_out_count", 32'(n_out), 32'd1000);
        check("random_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
